// File: rtl/wallace_mul_ctrl_if.sv
// Request/result handshake bundle for the multiplier control stage.
// The requester drives the request and result-ready side; the control stage drives the rest.
interface wallace_mul_ctrl_if #(
    parameter int ID_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [31:0]     in_a;
    logic [31:0]     in_b;
    logic [ID_W-1:0] in_id;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [ID_W-1:0] out_id;

    modport master (
        output in_valid, in_op, in_a, in_b, in_id, out_ready,
        input  in_ready, out_valid, out_result, out_id
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_id, out_ready,
        output in_ready, out_valid, out_result, out_id
    );
endinterface

// File: rtl/wallace_mul_ctrl.sv
// Multicycle control stage around a combinational 32x32 signed multiplier array:
// holds operands for WAIT_CYCLES, then registers the sign-corrected RISC-V result word.
module wallace_mul_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ID_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    wallace_mul_ctrl_if.slave  bus,
    output logic [31:0]        mul_x,
    output logic [31:0]        mul_y,
    input  logic [63:0]        mul_r,
    output logic               busy
);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [1:0]      op_reg;
    logic [ID_W-1:0] id_reg;
    logic [31:0]     mul_x_reg, mul_y_reg;
    logic [31:0]     out_result_reg;
    logic [ID_W-1:0] out_id_reg;

    logic        in_ready;
    logic        accept;
    logic        capture;
    logic [31:0] corr_a, corr_b;
    logic [31:0] result_next;
    logic [31:0] high_word;

    assign in_ready = rst_n & ~flush & ((state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready));
    assign accept   = bus.in_valid & in_ready;

    // corr_a adds a when b is negative as signed; corr_b adds b when a is negative.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_corr
            assign corr_a[gi] = mul_y_reg[31] & mul_x_reg[gi];
            assign corr_b[gi] = mul_x_reg[31] & mul_y_reg[gi];
        end
    endgenerate

    assign high_word = mul_r[63:32];

    always_comb begin
        result_next = mul_r[31:0];
        unique case (op_reg)
            2'b00: result_next = mul_r[31:0];
            2'b01: result_next = high_word;
            2'b10: result_next = high_word + corr_a;
            2'b11: result_next = high_word + corr_a + corr_b;
            default: result_next = mul_r[31:0];
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                    cnt_next   = CNT_INIT;
                end
            end
            CALC: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        state_next = CALC;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // flush kills everything, including a capture due this edge
        if (flush) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            op_reg         <= 2'b00;
            id_reg         <= '0;
            mul_x_reg      <= 32'd0;
            mul_y_reg      <= 32'd0;
            out_result_reg <= 32'd0;
            out_id_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                mul_x_reg <= bus.in_a;
                mul_y_reg <= bus.in_b;
                op_reg    <= bus.in_op;
                id_reg    <= bus.in_id;
            end
            if (capture) begin
                out_result_reg <= result_next;
                out_id_reg     <= id_reg;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.out_result = out_result_reg;
    assign bus.out_id     = out_id_reg;
    assign mul_x          = mul_x_reg;
    assign mul_y          = mul_y_reg;
    assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_wallace_mul_ctrl.sv
// Self-checking bench for wallace_mul_ctrl: directed corner cases plus random
// streaming, checked against a plain 64-bit arithmetic reference.
module tb_wallace_mul_ctrl;
    localparam int WAIT = 2;
    localparam int ID_W = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] mul_x, mul_y;
    logic [63:0] mul_r;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    wallace_mul_ctrl_if #(.ID_W(ID_W)) bus();

    wallace_mul_ctrl #(.WAIT_CYCLES(WAIT), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .mul_x (mul_x),
        .mul_y (mul_y),
        .mul_r (mul_r),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Behavioural signed array
    assign mul_r = $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: extend each operand per its signedness, multiply in 64 bits.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = op[1] ? {32'd0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] id);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_id    = id;
    endtask

    // Called at the negedge after the accept edge; counts edges until out_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] id, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        set_req(1'b1, op, a, b, id);
        #1 check("in_ready_idle", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("latency", lat, WAIT);
        check("result", bus.out_result, exp);
        check("out_id", bus.out_id, id);
        check("busy_done", busy, 1);
        check("mul_x_held", mul_x, a);
        check("mul_y_held", mul_y, b);
        $display("op=%0d a=%h b=%h id=%0d result=%h lat=%0d", op, a, b, id, bus.out_result, lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int lat, sent, got, cyc, last;
        bit acc, seen;
        logic [31:0] r0, ra, rb;
        logic [3:0]  i0;
        logic [1:0]  rop;
        logic [31:0] exp_q[$];
        logic [3:0]  id_q[$];

        set_req(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_x", mul_x, 0);
        check("rst_out_result", bus.out_result, 0);
        rst_n = 1'b1;

        // All-ones operands through every op
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'h00000001);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h00000000);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'hFFFFFFFF);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE);

        // Random single ops against the reference
        for (int i = 0; i < 4; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            run_op(rop, ra, rb, 4'(i + 7), ref_mul(rop, ra, rb));
        end

        // Back-pressure, then accept in the same cycle as the consume
        @(negedge clk);
        set_req(1'b1, 2'b00, 32'h12345678, 32'h00000010, 4'd5);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", lat, WAIT);
        r0 = bus.out_result;
        i0 = bus.out_id;
        check("bp_result", r0, 32'h23456780);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_result_stable", bus.out_result, r0);
            check("bp_id_stable", bus.out_id, i0);
            check("bp_valid_held", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_busy", busy, 1);
        end
        $display("op=0 a=12345678 b=00000010 id=5 result=%h held 5 cycles", r0);
        bus.out_ready = 1'b1;
        set_req(1'b1, 2'b11, 32'h80000000, 32'h00000002, 4'd6);
        #1 check("bp_accept_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp_new_calc_valid", bus.out_valid, 0);
        check("bp_new_calc_busy", busy, 1);
        wait_valid(lat);
        check("bp_new_latency", lat, WAIT);
        check("bp_new_result", bus.out_result, 32'h00000001);
        check("bp_new_id", bus.out_id, 4'd6);
        $display("op=3 a=80000000 b=00000002 id=6 result=%h", bus.out_result);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Streaming: in_valid and out_ready held high
        sent = 0; got = 0; cyc = 0; last = -1; acc = 0;
        bus.out_ready = 1'b1;
        rop = 2'($urandom_range(0, 3));
        set_req(1'b1, rop, $urandom, $urandom, 4'd0);
        while (got < 8 && cyc < 200) begin
            #1;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", bus.out_valid, 0);
                end else begin
                    check("stream_result", bus.out_result, exp_q.pop_front());
                    check("stream_id", bus.out_id, id_q.pop_front());
                    if (last >= 0) check("stream_interval", cyc - last, WAIT + 1);
                    $display("stream result %0d id=%0d result=%h cycle=%0d", got, bus.out_id, bus.out_result, cyc);
                    last = cyc;
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mul(bus.in_op, bus.in_a, bus.in_b));
                id_q.push_back(bus.in_id);
                sent++;
                acc = 1;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                acc = 0;
                if (sent < 8) begin
                    rop = 2'($urandom_range(0, 3));
                    set_req(1'b1, rop, $urandom, $urandom, 4'(sent));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        check("stream_count", got, 8);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);

        // Flush in the first CALC cycle with a competing request
        set_req(1'b1, 2'b01, 32'h80000000, 32'h80000000, 4'd3);
        @(negedge clk);
        set_req(1'b1, 2'b00, 32'd1, 32'd2, 4'd4);
        flush = 1'b1;
        #1 check("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("post_flush_in_ready", bus.in_ready, 1);
        check("post_flush_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 2 * WAIT + 2; i++) begin
            if (bus.out_valid) seen = 1;
            @(negedge clk);
        end
        check("flush_no_valid", seen, 0);
        $display("flushed op=1 id=3, no result delivered");
        run_op(2'b01, 32'h80000000, 32'h80000000, 4'd3, 32'h40000000);

        // Reset during DONE
        @(negedge clk);
        set_req(1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("pre_reset_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1 check("reset_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_result", bus.out_result, 0);
        check("reset_out_id", bus.out_id, 0);
        check("reset_mul_x", mul_x, 0);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid) seen = 1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("reset_no_delivery", seen, 0);
        $display("reset during DONE: pending op id=9 discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
